// File: rtl/enc_pkg.sv
// Shared constants and width helper for the priority-encoder family.
package enc_pkg;

  localparam int ENC_MODE_FIXED = 0;
  localparam int ENC_MODE_RR    = 1;

  // Index width for 2..64 request bits; never returns less than 1.
  function automatic int enc_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 7; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/enc_scan.sv
// Combinational find-first-set: scans upward from i_start, wrapping past N-1 to 0.
module enc_scan
  import enc_pkg::*;
#(
  parameter int N = 8,
  parameter int W = enc_width(N)
) (
  input  logic [N-1:0] i_vec,
  input  logic [W-1:0] i_start,
  output logic [W-1:0] o_idx,
  output logic         o_found
);

  // Bit position k steps past the start, folded back into 0..N-1.
  function automatic logic [W-1:0] wrap_pos(input logic [W-1:0] s, input int k);
    int j;
    j = int'(s) + k;
    if (j >= N) j = j - N;
    return W'(j);
  endfunction

  // Walk from the far end back toward the start so the nearest hit is written last.
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_vec[wrap_pos(i_start, k)]) begin
        o_idx   = wrap_pos(i_start, k);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/enc_prio_hs.sv
// N-to-log2(N) priority encoder with a registered, valid/ready-handshaked result.
module enc_prio_hs
  import enc_pkg::*;
#(
  parameter  int N    = 8,
  parameter  int MODE = ENC_MODE_FIXED,
  localparam int W    = enc_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [N-1:0] in_req,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_idx,
  output logic         out_any,
  output logic         out_multi
);

  logic         r_vld;
  logic [W-1:0] r_idx;
  logic         r_any;
  logic         r_multi;

  logic [W-1:0] w_idx;
  logic         w_found;
  logic         w_accept;
  logic         w_any;
  logic         w_multi;

  assign in_rdy   = !rst && (!r_vld || out_rdy);
  assign w_accept = in_vld && in_rdy;
  assign w_any    = |in_req;
  // Clearing the lowest set bit leaves something only when two or more bits were set.
  assign w_multi  = |(in_req & (in_req - N'(1)));

  if (MODE == ENC_MODE_RR) begin : g_rr
    logic [W-1:0] r_ptr;

    enc_scan #(.N(N), .W(W)) u_scan (
      .i_vec  (in_req),
      .i_start(r_ptr),
      .o_idx  (w_idx),
      .o_found(w_found)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        r_ptr <= '0;
      end else if (w_accept && w_found) begin
        r_ptr <= (w_idx == W'(N - 1)) ? '0 : w_idx + W'(1);
      end
    end
  end else begin : g_fix
    logic [N-1:0] w_rev;
    logic [W-1:0] w_pos;

    // Highest set bit becomes the lowest set bit of the mirrored vector.
    for (genvar gi = 0; gi < N; gi++) begin : g_rev
      assign w_rev[gi] = in_req[N-1-gi];
    end

    enc_scan #(.N(N), .W(W)) u_scan (
      .i_vec  (w_rev),
      .i_start('0),
      .o_idx  (w_pos),
      .o_found(w_found)
    );

    assign w_idx = W'(N - 1) - w_pos;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld   <= 1'b0;
      r_idx   <= '0;
      r_any   <= 1'b0;
      r_multi <= 1'b0;
    end else if (w_accept) begin
      r_vld   <= 1'b1;
      r_idx   <= w_found ? w_idx : '0;
      r_any   <= w_any;
      r_multi <= w_multi;
    end else if (r_vld && out_rdy) begin
      r_vld   <= 1'b0;
    end
  end

  assign out_vld   = r_vld;
  assign out_idx   = r_idx;
  assign out_any   = r_any;
  assign out_multi = r_multi;

endmodule
